adc_capture_ctrl: RTL and testbench
===================================

// Module: adc_capture_ctrl
// PURPOSE
// - Acquisition sequencer for one oscilloscope channel pair. Sits between the parallel ADC input stage
//   (AXI-Stream master) and the sample buffer/DMA.
// - Arms on request, drives the ADC stage ce, and forwards a pre-trigger run-in.
// - Detects a level/edge trigger, forwards post_len further samples, ends the frame with tlast, then parks.
// PARAMETERS
// - DW_BUS  16   stream data width; also the trigger compare width (unsigned)
// - CW      16   width of the pre/post sample counters
// - TRIG_ID 0    tid value of the stream channel that the trigger watches
// PORTS
// - aclk             in   1       sole clock
// - aresetn          in   1       async active-low reset
// - arm              in   1       1-cycle pulse: start a capture (accepted in IDLE/DONE only)
// - abort            in   1       1-cycle pulse: cancel from any state
// - force_trig       in   1       1-cycle pulse: trigger immediately (valid in WAIT_TRIG)
// - trig_level       in   DW_BUS  threshold
// - trig_falling     in   1       0 = rising edge, 1 = falling edge
// - pre_len          in   CW      samples forwarded before the trigger is enabled
// - post_len         in   CW      samples after the trigger sample
// - adc_ce           out  1       enable to the ADC input stage
// - s_tdata          in   DW_BUS  upstream sample
// - s_tid            in   1       upstream channel id
// - s_tvalid         in   1       upstream valid
// - s_tready         out  1       upstream ready
// - m_tdata          out  DW_BUS  downstream sample
// - m_tid            out  1       downstream channel id
// - m_tuser          out  1       marks the trigger sample
// - m_tlast          out  1       marks the last beat of a frame
// - m_tvalid         out  1       downstream valid
// - m_tready         in   1       downstream ready
// - state_out        out  3       current FSM state code
// - done             out  1       1-cycle pulse on entry to DONE
// BEHAVIOUR
// - Reset: FSM = IDLE; every output = 0, except s_tready = 1.
// - States: IDLE -> (arm) PRETRIG -> (pre_len samples accepted) WAIT_TRIG -> (trigger) POST
//   -> (post_len samples after the trigger sample) DONE -> (arm) PRETRIG.
//   - pre_len = 0: PRETRIG exits after the first accepted sample is counted against 0, i.e. directly to WAIT_TRIG.
// - adc_ce = 1 in PRETRIG, WAIT_TRIG and POST; 0 otherwise.
// - Output stage: one register. Accept upstream when (!m_tvalid || m_tready). Latency 1 cycle.
//   - s_tready = that condition while capturing.
//   - s_tready = 1 in IDLE/DONE; samples offered there are discarded.
// - Trigger: evaluated only on accepted beats with s_tid == TRIG_ID in WAIT_TRIG.
//   - Rising: prev < level && cur >= level.
//   - Falling: prev >= level && cur < level.
//   - prev register: holds the last TRIG_ID sample; its valid flag clears on arm.
//   - No trigger is possible before one TRIG_ID sample has been seen.
//   - force_trig: makes the next accepted beat (any tid) the trigger sample.
// - Trigger sample: m_tuser = 1; the post counter is cleared.
//   - Each later accepted beat increments the counter.
//   - The beat at count == post_len carries m_tlast = 1 and moves the FSM to DONE.
//   - post_len = 0: the trigger sample itself carries tlast.
// - Simultaneous events:
//   - abort beats arm and force_trig.
//   - A trigger on the same beat that completes pre_len is ignored; the trigger arms from the next beat.
// - abort: next state is IDLE and no new beats are accepted.
//   - An already-valid m_ beat is held until m_tready, with m_tlast forced to 1.
//   - done is not pulsed.
// - arm outside IDLE/DONE is ignored.
// - Counters saturate at 2^CW-1 and never wrap. pre_len/post_len are sampled into registers on arm.
// - Reset mid-capture: immediate IDLE; m_tvalid drops asynchronously.
// STRUCTURE
// - capture_defs.vh: state localparams (IDLE=0, PRETRIG=1, WAIT_TRIG=2, POST=3, DONE=4),
//   shared with the register-map block.
// - Sub-module capture_trig_detect: holds the prev register and its valid flag, compares against the
//   level and edge, outputs a 1-bit hit.
// TESTING
// - pre_len=4, post_len=3, level=0x8000, ramp 0x7000 step 0x0400 on tid 0:
//   - trigger fires on 0x8000 with tuser=1;
//   - 3 more beats follow, the last with tlast=1;
//   - done pulses once; adc_ce = 0 afterwards.
// - Falling edge, level=0x4000, samples 0x5000, 0x3000:
//   - trigger fires on the 0x3000 beat;
//   - a matching crossing on tid 1 does not trigger.
// - post_len=0, force_trig in WAIT_TRIG:
//   - the next beat has tuser=1 and tlast=1; FSM goes to DONE.
// - m_tready toggled 1/0 every cycle during POST:
//   - no beats are lost or duplicated; m_tdata stays stable while stalled; beat count = post_len+1.
// - abort in POST with a stalled valid beat:
//   - the beat is held with tlast=1 until m_tready;
//   - FSM goes to IDLE; done = 0; s_tready = 1.
// - aresetn low mid-POST, then arm:
//   - all outputs are 0 and s_tready = 1 during reset;
//   - after arm the capture runs normally; the first TRIG_ID sample cannot trigger.

Source files
------------

// File: rtl/adc_capture_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// adc_capture_ctrl_pkg
// Shared definitions for the acquisition sequencer: FSM state encoding (the
// numeric codes are visible on state_out and are also decoded by the
// register-map block) and a small helper.
// ---------------------------------------------------------------------------
package adc_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRETRIG   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } cap_state_e;

    // States in which the ADC stage is enabled and beats are forwarded.
    function automatic logic is_capturing(input cap_state_e s);
        return (s == ST_PRETRIG) || (s == ST_WAIT_TRIG) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/capture_trig_detect.sv
// ---------------------------------------------------------------------------
// capture_trig_detect
// Level/edge trigger comparator. Keeps the previous watched-channel sample and
// a valid flag; hit is asserted when the current sample crosses the level in
// the selected direction relative to that previous sample.
// Ports:
//   aclk, aresetn   clock, async active-low reset
//   clear           drops the prev-valid flag (new capture armed)
//   sample_en       current sample is an accepted watched-channel beat
//   cur             current sample
//   level           threshold (unsigned)
//   falling         0 = rising edge, 1 = falling edge
//   hit             combinational crossing indication for cur
// ---------------------------------------------------------------------------
module capture_trig_detect #(
    parameter int DW = 16
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          clear,
    input  logic          sample_en,
    input  logic [DW-1:0] cur,
    input  logic [DW-1:0] level,
    input  logic          falling,
    output logic          hit
);

    logic [DW-1:0] prev_q, prev_d;
    logic          prev_valid_q, prev_valid_d;

    always_comb begin
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        if (clear) begin
            prev_valid_d = 1'b0;
        end else if (sample_en) begin
            prev_d       = cur;
            prev_valid_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    // Without a previous sample there is no edge to detect.
    assign hit = prev_valid_q &&
                 (falling ? ((prev_q >= level) && (cur <  level))
                          : ((prev_q <  level) && (cur >= level)));

endmodule

// File: rtl/adc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// adc_capture_ctrl
// Acquisition sequencer for one oscilloscope channel pair. Arms on request,
// enables the ADC stage, forwards a pre-trigger run-in, waits for a level/edge
// trigger (or force_trig), forwards post_len further beats, closes the frame
// with tlast and parks in DONE.
// Ports:
//   aclk, aresetn                  clock, async active-low reset
//   arm, abort, force_trig         1-cycle control pulses
//   trig_level, trig_falling       trigger threshold and edge select
//   pre_len, post_len              run-in / post-trigger lengths (sampled on arm)
//   adc_ce                         ADC stage enable
//   s_t*                           upstream AXI-Stream slave
//   m_t*                           downstream AXI-Stream master (1 register stage)
//   state_out                      current FSM state code
//   done                           1-cycle pulse on entry to DONE
// ---------------------------------------------------------------------------
module adc_capture_ctrl
    import adc_capture_ctrl_pkg::*;
#(
    parameter int DW_BUS  = 16,
    parameter int CW      = 16,
    parameter bit TRIG_ID = 1'b0
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              arm,
    input  logic              abort,
    input  logic              force_trig,
    input  logic [DW_BUS-1:0] trig_level,
    input  logic              trig_falling,
    input  logic [CW-1:0]     pre_len,
    input  logic [CW-1:0]     post_len,
    output logic              adc_ce,
    input  logic [DW_BUS-1:0] s_tdata,
    input  logic              s_tid,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DW_BUS-1:0] m_tdata,
    output logic              m_tid,
    output logic              m_tuser,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [2:0]        state_out,
    output logic              done
);

    cap_state_e        state_q, state_d;
    logic [CW-1:0]     pre_len_q, pre_len_d;
    logic [CW-1:0]     post_len_q, post_len_d;
    logic [CW-1:0]     cnt_q, cnt_d;          // pre count in PRETRIG, post count in POST
    logic              force_pend_q, force_pend_d;
    logic [DW_BUS-1:0] m_tdata_q, m_tdata_d;
    logic              m_tid_q, m_tid_d;
    logic              m_tuser_q, m_tuser_d;
    logic              m_tlast_q, m_tlast_d;
    logic              m_tvalid_q, m_tvalid_d;
    logic              done_q, done_d;

    logic              capturing;
    logic              out_free;
    logic              accept;
    logic              arm_ok;
    logic              trig_sample;
    logic              trig_hit;
    logic              trig_fire;
    logic [CW-1:0]     cnt_inc;

    assign capturing   = is_capturing(state_q);
    assign out_free    = !m_tvalid_q || m_tready;
    // abort closes the input on the same cycle it is seen.
    assign accept      = capturing && s_tvalid && out_free && !abort;
    assign arm_ok      = arm && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign trig_sample = accept && (s_tid == TRIG_ID);
    assign trig_fire   = (state_q == ST_WAIT_TRIG) && accept &&
                         (force_pend_q || force_trig || (trig_sample && trig_hit));
    assign cnt_inc     = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    capture_trig_detect #(
        .DW (DW_BUS)
    ) u_trig (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .clear     (arm_ok),
        .sample_en (trig_sample),
        .cur       (s_tdata),
        .level     (trig_level),
        .falling   (trig_falling),
        .hit       (trig_hit)
    );

    always_comb begin
        state_d      = state_q;
        pre_len_d    = pre_len_q;
        post_len_d   = post_len_q;
        cnt_d        = cnt_q;
        force_pend_d = force_pend_q;
        m_tdata_d    = m_tdata_q;
        m_tid_d      = m_tid_q;
        m_tuser_d    = m_tuser_q;
        m_tlast_d    = m_tlast_q;
        m_tvalid_d   = m_tvalid_q;

        // Output register: load on accept, otherwise drain on m_tready.
        if (accept) begin
            m_tdata_d  = s_tdata;
            m_tid_d    = s_tid;
            m_tuser_d  = trig_fire;
            m_tlast_d  = (trig_fire && (post_len_q == '0)) ||
                         ((state_q == ST_POST) && (cnt_inc == post_len_q));
            m_tvalid_d = 1'b1;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_ok) begin
                    state_d      = ST_PRETRIG;
                    pre_len_d    = pre_len;
                    post_len_d   = post_len;
                    cnt_d        = '0;
                    force_pend_d = 1'b0;
                end
            end
            ST_PRETRIG: begin
                // Triggering is only evaluated from WAIT_TRIG, so a crossing on
                // the beat that completes the run-in is ignored by construction.
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= pre_len_q) begin
                        state_d = ST_WAIT_TRIG;
                    end
                end
            end
            ST_WAIT_TRIG: begin
                if (force_trig) begin
                    force_pend_d = 1'b1;
                end
                if (trig_fire) begin
                    cnt_d        = '0;
                    force_pend_d = 1'b0;
                    state_d      = (post_len_q == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == post_len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d      = ST_IDLE;
            force_pend_d = 1'b0;
            // A stalled beat becomes the end of the truncated frame.
            if (m_tvalid_q && !m_tready) begin
                m_tlast_d = 1'b1;
            end
        end

        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            pre_len_q    <= '0;
            post_len_q   <= '0;
            cnt_q        <= '0;
            force_pend_q <= 1'b0;
            m_tdata_q    <= '0;
            m_tid_q      <= 1'b0;
            m_tuser_q    <= 1'b0;
            m_tlast_q    <= 1'b0;
            m_tvalid_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_len_q    <= pre_len_d;
            post_len_q   <= post_len_d;
            cnt_q        <= cnt_d;
            force_pend_q <= force_pend_d;
            m_tdata_q    <= m_tdata_d;
            m_tid_q      <= m_tid_d;
            m_tuser_q    <= m_tuser_d;
            m_tlast_q    <= m_tlast_d;
            m_tvalid_q   <= m_tvalid_d;
            done_q       <= done_d;
        end
    end

    assign adc_ce    = capturing;
    assign s_tready  = capturing ? (out_free && !abort) : 1'b1;
    assign m_tdata   = m_tdata_q;
    assign m_tid     = m_tid_q;
    assign m_tuser   = m_tuser_q;
    assign m_tlast   = m_tlast_q;
    assign m_tvalid  = m_tvalid_q;
    assign state_out = state_q;
    assign done      = done_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc_capture_ctrl
// Directed stimulus with a scoreboard: each forwarded beat's expected
// {data,tid,tuser,tlast} is queued when it is driven; a negedge monitor pops
// and compares on every downstream handshake.
// ---------------------------------------------------------------------------
module tb_adc_capture_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        arm = 1'b0, abort = 1'b0, force_trig = 1'b0;
    logic [15:0] trig_level = 16'h0;
    logic        trig_falling = 1'b0;
    logic [15:0] pre_len = 16'd0, post_len = 16'd0;
    logic        adc_ce;
    logic [15:0] s_tdata = 16'h0;
    logic        s_tid = 1'b0, s_tvalid = 1'b0;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic        m_tid, m_tuser, m_tlast, m_tvalid;
    logic        m_tready = 1'b1;
    logic [2:0]  state_out;
    logic        done;

    always #5 aclk = ~aclk;

    adc_capture_ctrl dut (
        .aclk(aclk), .aresetn(aresetn), .arm(arm), .abort(abort), .force_trig(force_trig),
        .trig_level(trig_level), .trig_falling(trig_falling), .pre_len(pre_len), .post_len(post_len),
        .adc_ce(adc_ce), .s_tdata(s_tdata), .s_tid(s_tid), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tid(m_tid), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .state_out(state_out), .done(done)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        id;
        logic        u;
        logic        l;
    } beat_t;

    beat_t       sb[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          beats = 0;
    bit          stall_chk = 1'b0;
    logic [15:0] held_d = 16'h0;
    bit          tog_stop = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
            $display("check %s: got %0h", name, act);
        end else begin
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: handshake completes at the coming posedge when valid&ready here.
    always @(negedge aclk) begin
        if (!aresetn) begin
            stall_chk = 1'b0;
        end else begin
            if (stall_chk && m_tvalid) chk("stall_hold", {16'h0, m_tdata}, {16'h0, held_d});
            stall_chk = m_tvalid && !m_tready;
            held_d    = m_tdata;
            if (m_tvalid && m_tready) begin
                beat_t e;
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_beat: got %0h want none", m_tdata);
                end else begin
                    e = sb.pop_front();
                    chk("beat", {13'h0, m_tdata, m_tid, m_tuser, m_tlast}, {13'h0, e});
                end
                beats++;
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic id, input bit fwd, input logic u, input logic l);
        beat_t e;
        e = '{d: d, id: id, u: u, l: l};
        if (fwd) sb.push_back(e);
        s_tdata  = d;
        s_tid    = id;
        s_tvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (s_tready) begin
                @(posedge aclk);
                #1;
                s_tvalid = 1'b0;
                return;
            end
        end
        s_tvalid = 1'b0;
        n_total++;
        $display("FAIL send_timeout: got s_tready=0 want 1 (data %0h)", d);
    endtask

    task automatic pulse(input int which);
        case (which)
            0: arm = 1'b1;
            1: abort = 1'b1;
            default: force_trig = 1'b1;
        endcase
        @(posedge aclk);
        #1;
        arm = 1'b0;
        abort = 1'b0;
        force_trig = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) return;
            @(posedge aclk);
            #1;
        end
        n_total++;
        $display("FAIL drain_timeout: got %0d queued want 0", sb.size());
        sb.delete();
    endtask

    task automatic setup(input logic [15:0] pl, input logic [15:0] ql,
                         input logic [15:0] lvl, input logic fall);
        pre_len = pl;
        post_len = ql;
        trig_level = lvl;
        trig_falling = fall;
        pulse(0);
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        // Reset state
        chk("rst_state", {29'h0, state_out}, 32'd0);
        chk("rst_outs", {26'h0, adc_ce, m_tvalid, m_tuser, m_tlast, done, s_tready}, 32'b000001);
        chk("rst_data", {16'h0, m_tdata}, 32'h0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // 1: rising ramp, pre 4, post 3
        setup(16'd4, 16'd3, 16'h8000, 1'b0);
        chk("t1_pretrig", {29'h0, state_out}, 32'd1);
        chk("t1_ce_on", {31'h0, adc_ce}, 32'd1);
        for (int k = 0; k < 4; k++) send(16'h7000 + 16'(k * 16'h0400), 1'b0, 1, 1'b0, 1'b0);
        chk("t1_wait", {29'h0, state_out}, 32'd2);
        send(16'h8000, 1'b0, 1, 1'b1, 1'b0);
        chk("t1_post", {29'h0, state_out}, 32'd3);
        send(16'h8400, 1'b0, 1, 1'b0, 1'b0);
        send(16'h8800, 1'b0, 1, 1'b0, 1'b0);
        send(16'h8C00, 1'b0, 1, 1'b0, 1'b1);
        chk("t1_done_pulse", {28'h0, state_out, done}, {28'h0, 3'd4, 1'b1});
        @(posedge aclk);
        #1;
        chk("t1_done_low_ce_off", {30'h0, done, adc_ce}, 32'd0);
        drain();

        // 2a: crossing on the beat that completes pre_len is ignored; post_len 0
        setup(16'd2, 16'd0, 16'h8000, 1'b0);
        send(16'h7000, 1'b0, 1, 1'b0, 1'b0);
        send(16'h9000, 1'b0, 1, 1'b0, 1'b0);
        chk("t2a_no_trig_on_pre", {29'h0, state_out}, 32'd2);
        send(16'h9400, 1'b0, 1, 1'b0, 1'b0);
        send(16'h7000, 1'b0, 1, 1'b0, 1'b0);
        chk("t2a_still_wait", {29'h0, state_out}, 32'd2);
        send(16'h8000, 1'b0, 1, 1'b1, 1'b1);
        chk("t2a_done", {29'h0, state_out}, 32'd4);
        drain();

        // 2b: falling edge, tid 1 crossing ignored
        setup(16'd0, 16'd1, 16'h4000, 1'b1);
        send(16'h5000, 1'b0, 1, 1'b0, 1'b0);
        chk("t2b_wait", {29'h0, state_out}, 32'd2);
        send(16'h5000, 1'b1, 1, 1'b0, 1'b0);
        send(16'h3000, 1'b1, 1, 1'b0, 1'b0);
        chk("t2b_tid1_no_trig", {29'h0, state_out}, 32'd2);
        send(16'h3000, 1'b0, 1, 1'b1, 1'b0);
        chk("t2b_post", {29'h0, state_out}, 32'd3);
        send(16'h2000, 1'b0, 1, 1'b0, 1'b1);
        chk("t2b_done", {29'h0, state_out}, 32'd4);
        drain();

        // 3: force_trig with post_len 0
        setup(16'd0, 16'd0, 16'h8000, 1'b0);
        send(16'h1234, 1'b1, 1, 1'b0, 1'b0);
        pulse(2);
        chk("t3_wait_after_force", {29'h0, state_out}, 32'd2);
        send(16'h0001, 1'b1, 1, 1'b1, 1'b1);
        chk("t3_done", {28'h0, state_out, done}, {28'h0, 3'd4, 1'b1});
        drain();

        // 4: m_tready toggling during POST
        setup(16'd0, 16'd3, 16'h8000, 1'b0);
        send(16'h1000, 1'b0, 1, 1'b0, 1'b0);
        drain();
        beats = 0;
        send(16'h9000, 1'b0, 1, 1'b1, 1'b0);
        tog_stop = 1'b0;
        fork
            begin
                while (!tog_stop) begin
                    @(posedge aclk);
                    #1;
                    m_tready = ~m_tready;
                end
            end
        join_none
        send(16'hA001, 1'b1, 1, 1'b0, 1'b0);
        send(16'hA002, 1'b1, 1, 1'b0, 1'b0);
        send(16'hA003, 1'b1, 1, 1'b0, 1'b1);
        tog_stop = 1'b1;
        @(posedge aclk);
        #2;
        m_tready = 1'b1;
        drain();
        chk("t4_beat_count", beats, 32'd4);
        chk("t4_done_state", {29'h0, state_out}, 32'd4);

        // 5: abort in POST with a stalled beat
        setup(16'd0, 16'd5, 16'h8000, 1'b0);
        send(16'h1000, 1'b0, 1, 1'b0, 1'b0);
        drain();
        m_tready = 1'b0;
        send(16'h9000, 1'b0, 1, 1'b1, 1'b1);
        pulse(1);
        chk("t5_idle", {29'h0, state_out}, 32'd0);
        chk("t5_held", {12'h0, m_tdata, m_tvalid, m_tlast, s_tready, done},
                       {12'h0, 16'h9000, 1'b1, 1'b1, 1'b1, 1'b0});
        send(16'h5555, 1'b0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge aclk);
        #1;
        chk("t5_still_held", {30'h0, m_tvalid, m_tlast}, 32'b11);
        m_tready = 1'b1;
        drain();
        @(posedge aclk);
        #1;
        chk("t5_drained", {30'h0, m_tvalid, done}, 32'd0);

        // 6: reset mid-POST, then a normal capture
        setup(16'd0, 16'd5, 16'h8000, 1'b0);
        send(16'h1000, 1'b0, 1, 1'b0, 1'b0);
        drain();
        m_tready = 1'b0;
        send(16'h9000, 1'b0, 0, 1'b0, 1'b0);
        chk("t6_in_post", {29'h0, state_out}, 32'd3);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_outs", {26'h0, adc_ce, m_tvalid, m_tuser, m_tlast, done, s_tready}, 32'b000001);
        chk("t6_rst_state_data", {13'h0, state_out, m_tdata}, 32'h0);
        m_tready = 1'b1;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        setup(16'd0, 16'd1, 16'h8000, 1'b0);
        send(16'h0000, 1'b1, 1, 1'b0, 1'b0);
        send(16'h9000, 1'b0, 1, 1'b0, 1'b0);
        chk("t6_first_sample_no_trig", {29'h0, state_out}, 32'd2);
        send(16'h7000, 1'b0, 1, 1'b0, 1'b0);
        send(16'h8800, 1'b0, 1, 1'b1, 1'b0);
        chk("t6_post", {29'h0, state_out}, 32'd3);
        send(16'h8900, 1'b0, 1, 1'b0, 1'b1);
        chk("t6_done", {28'h0, state_out, done}, {28'h0, 3'd4, 1'b1});
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

endmodule
